// File: rtl/onewire_mc_if.sv
// Avalon-MM register port of the multi-channel 1-Wire master.
// The master modport is the interconnect side and the slave modport is the
// onewire_mc side.
interface onewire_mc_if;
  logic        avalon_read;
  logic        avalon_write;
  logic [31:0] avalon_writedata;
  logic [31:0] avalon_readdata;
  logic        avalon_waitrequest;
  logic        avalon_interrupt;

  modport master (
    output avalon_read, avalon_write, avalon_writedata,
    input  avalon_readdata, avalon_waitrequest, avalon_interrupt
  );

  modport slave (
    input  avalon_read, avalon_write, avalon_writedata,
    output avalon_readdata, avalon_waitrequest, avalon_interrupt
  );
endinterface

// File: rtl/onewire_mc.sv
// Multi-channel 1-Wire bus master behind an Avalon-MM register port.
// Each register write launches one reset cycle or one bit slot on channel
// SEL. The master times the slot and samples the selected line.
// Optional feature macro OWM_OVD_EN: when it is defined, the OVD bit is
// writable and selects the overdrive tick period CDR_O. When it is not
// defined, OVD stays 0 and there is no overdrive logic.
module onewire_mc #(
  parameter int OWN   = 1,
  parameter int CDR_N = 120,
  parameter int CDR_O = 15
) (
  input  logic             clk,
  input  logic             rst,
  onewire_mc_if.slave      bus,
  inout  tri   [OWN-1:0]   onewire
);

  localparam int SW   = (OWN > 1) ? $clog2(OWN) : 1;
  localparam int CMAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
  localparam int PW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, LOW, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   sel;
  logic            cmd_dat, rst_bit, ovd, ien, irq, dat;
  logic [7:0]      t, t_inc, low_t, samp_t, end_t;
  logic [PW-1:0]   presc, presc_last;
  logic            tick, accept, busy, end_evt;
  logic            line_sel, sync1, sync2;
  logic [OWN-1:0]  line_in, drive_low;
  logic [31:0]     rd;
  logic            unused_bits;

  assign line_in     = onewire;
  assign unused_bits = ^{bus.avalon_writedata[31:8+SW], bus.avalon_writedata[7:4],
                         bus.avalon_writedata[2]};

`ifndef OWM_OVD_EN
  assign ovd = 1'b0;
`endif

  // Tick generation, slot milestones and command acceptance.
  always_comb begin
    busy   = (state != IDLE);
    accept = bus.avalon_write && !busy;
`ifdef OWM_OVD_EN
    presc_last = ovd ? PW'(CDR_O - 1) : PW'(CDR_N - 1);
`else
    presc_last = PW'(CDR_N - 1);
`endif
    tick    = busy && (presc == presc_last);
    t_inc   = t + 8'd1;
    low_t   = rst_bit ? 8'd96 : (cmd_dat ? 8'd1 : 8'd12);
    samp_t  = rst_bit ? 8'd110 : 8'd3;
    end_t   = rst_bit ? 8'd192 : 8'd13;
    end_evt = (state == RELEASE) && tick && (t_inc == end_t);
  end

  // Pick the addressed line. An out-of-range SEL reads as a released line.
  always_comb begin
    line_sel = 1'b1;
    for (int i = 0; i < OWN; i++) begin
      if (sel == SW'(i)) line_sel = line_in[i];
    end
  end

  // Two-flop synchroniser so the sample point sees a settled level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line_sel;
      sync2 <= sync1;
    end
  end

  // Control fields, the timebase counters, the sampled bit and the IRQ flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= '0;
      cmd_dat <= 1'b0;
      rst_bit <= 1'b0;
      ien     <= 1'b0;
      irq     <= 1'b0;
      dat     <= 1'b0;
      t       <= '0;
      presc   <= '0;
`ifdef OWM_OVD_EN
      ovd     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        sel     <= bus.avalon_writedata[8 +: SW];
        cmd_dat <= bus.avalon_writedata[0];
        dat     <= bus.avalon_writedata[0];
        rst_bit <= bus.avalon_writedata[1];
        ien     <= bus.avalon_writedata[3];
`ifdef OWM_OVD_EN
        ovd     <= bus.avalon_writedata[2];
`endif
        t       <= '0;
        presc   <= '0;
      end else if (busy) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) t <= t_inc;
        if (tick && (t_inc == samp_t)) dat <= sync2;
      end
      if (accept) irq <= 1'b0;
      else if (end_evt) irq <= 1'b1;
      else if (bus.avalon_read) irq <= 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slot sequencing: pull low, release, then finish at the end tick.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOW;
      LOW:     if (tick && (t_inc == low_t)) state_nxt = RELEASE;
      RELEASE: if (end_evt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line drivers, status word and bus handshake outputs.
  always_comb begin
    for (int i = 0; i < OWN; i++) begin
      drive_low[i] = (state == LOW) && (sel == SW'(i));
    end
    rd              = '0;
    rd[0]           = dat;
    rd[1]           = rst_bit;
    rd[2]           = ovd;
    rd[3]           = ien;
    rd[4]           = (state == IDLE);
    rd[5]           = irq;
    rd[8 +: SW]     = sel;
    bus.avalon_readdata    = rd;
    bus.avalon_waitrequest = bus.avalon_write && busy;
    bus.avalon_interrupt   = ien && irq;
  end

  genvar g;
  generate
    for (g = 0; g < OWN; g++) begin : g_drv
      assign onewire[g] = drive_low[g] ? 1'b0 : 1'bz;
    end
  endgenerate

endmodule
